branch_direction_predictor: RTL and testbench
=============================================

# branch_direction_predictor

Gshare-style conditional-branch direction predictor in the fetch unit. Holds a table of 2-bit saturating counters (PHT) and the 4-bit speculative global branch history register (GHR). It predicts the direction of each fetched branch, and its outputs feed the branch-predict generation stage directly as the taken prediction and history snapshot. Counters are trained, and the GHR is repaired, from branch resolution in the execute stage.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC width (matches the PC type)
- PHT_INDEX_WIDTH, 6, log2 of PHT entries; must be ≥ 4
- HISTORY_WIDTH, 4, GHR width; fixed at 4 to match the BranchPredict history field

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- fetchValid  in  1  fetch slot holds a valid instruction
- fetchPc  in  ADDR_WIDTH  PC of fetched instruction
- isBranch  in  1  fetched instruction is a conditional branch
- stall  in  1  fetch stalled; no speculative state change
- isBranchTakenPredicted  out  1  predicted direction for fetchPc
- globalBranchHistory  out  HISTORY_WIDTH  GHR value used for this lookup; carried with the instruction
- predictorReady  out  1  table initialised; predictions valid
- updateValid  in  1  execute stage resolved a conditional branch
- updatePc  in  ADDR_WIDTH  PC of resolved branch
- updateHistory  in  HISTORY_WIDTH  history snapshot carried with the resolved branch
- updateTaken  in  1  actual direction
- updateMispredicted  in  1  direction was mispredicted

## Operation
- Index, with the macro enabled: idx = fetchPc[PHT_INDEX_WIDTH+1:2] XOR zero-extended GHR. Update index uses updatePc and updateHistory the same way.
- Prediction: isBranchTakenPredicted = PHT[idx][1] when in READY; otherwise 0.
- globalBranchHistory = current GHR, which is the pre-update value.
- FSM states:
  - INIT: sweep counter increments 0..2^PHT_INDEX_WIDTH−1, writing 2'b01 (weakly not-taken) into one entry per cycle. predictorReady=0. Updates and speculative GHR shifts are ignored.
  - INIT → READY after the last entry is written.
  - READY: normal operation; predictorReady=1. There is no exit from READY except reset.
- Speculative GHR update: when READY && fetchValid && isBranch && !stall, GHR ← {GHR[2:0], isBranchTakenPredicted}.
- Repair: when READY && updateValid && updateMispredicted, GHR ← {updateHistory[2:0], updateTaken}. Repair has priority over a same-cycle speculative shift, and the speculative shift is dropped.
- Training: when READY && updateValid, the counter at the update index saturating-increments if updateTaken, otherwise saturating-decrements. Range 0..3; no wrap.
- Same-cycle lookup and update to the same entry: the lookup sees the old value.

## Timing
- Lookup is combinational: fetchPc → isBranchTakenPredicted in the same cycle.
- GHR and PHT writes take effect at the next clk edge and are visible to the lookup in the following cycle.
- Init sweep lasts exactly 2^PHT_INDEX_WIDTH cycles after rst deasserts. predictorReady rises on the next cycle after the sweep.
- Reset values:
  - GHR=0
  - FSM=INIT, sweep counter=0
  - predictorReady=0
  - isBranchTakenPredicted=0
  - globalBranchHistory=0
- rst asserted mid-sweep or in READY restarts the sweep from entry 0 and clears GHR.
- stall held: GHR is unchanged, and training still occurs.

## Configuration
- BRANCH_PREDICTOR_GSHARE_EN defined: the index is XORed with the history, as above.
- Not defined: bimodal. The index is the PC bits only, for both lookup and update. The GHR is still maintained, repaired and output, so the downstream history field stays valid.

## Test plan
- Reset, PHT_INDEX_WIDTH=6: predictorReady=0 for 64 cycles, then 1. Every entry reads not-taken. globalBranchHistory=0.
- Train 0x100 with history 0: two taken updates → prediction for 0x100 with GHR=0 is 1. One not-taken update → still 1 (counter at 2). A second not-taken update → 0.
- Saturation: 5 taken updates, then 1 not-taken → predicts taken. 5 not-taken updates, then 1 taken → predicts not-taken.
- GHR: three unstalled predicted-taken branches from reset → GHR=4'b0111. A stalled branch leaves it unchanged. A mispredict with updateHistory=4'b1010, updateTaken=0, issued in the same cycle as a speculative fetch → GHR=4'b0100.
- Gshare enabled: 0x100 trained taken with history 4'b0000 does not affect lookup with GHR=4'b0001. Disabled: the same entry is shared, and the lookup predicts taken.
- rst asserted at sweep cycle 30 → predictorReady stays 0 for a full 64 cycles after deassertion. An update during INIT has no effect.

Source files
------------

// File: rtl/branch_direction_predictor.sv
// Branch direction predictor: table of 2-bit saturating counters plus a speculative global history.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR the history into the table index; otherwise bimodal.
module branch_direction_predictor #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned PHT_INDEX_WIDTH = 6,
  parameter int unsigned HISTORY_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetchValid,
  input  logic [ADDR_WIDTH-1:0]    fetchPc,
  input  logic                     isBranch,
  input  logic                     stall,
  output logic                     isBranchTakenPredicted,
  output logic [HISTORY_WIDTH-1:0] globalBranchHistory,
  output logic                     predictorReady,
  input  logic                     updateValid,
  input  logic [ADDR_WIDTH-1:0]    updatePc,
  input  logic [HISTORY_WIDTH-1:0] updateHistory,
  input  logic                     updateTaken,
  input  logic                     updateMispredicted
);
  localparam int unsigned PhtEntries = 2 ** PHT_INDEX_WIDTH;

  localparam logic [0:0] StInit  = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [PHT_INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic [HISTORY_WIDTH-1:0]   ghr_q, ghr_d;
  logic [1:0]                 pht_q [PhtEntries];

  logic [PHT_INDEX_WIDTH-1:0] fetch_idx;
  logic [PHT_INDEX_WIDTH-1:0] update_idx;
  logic [PHT_INDEX_WIDTH-1:0] pht_waddr;
  logic [1:0]                 pht_wdata;
  logic [1:0]                 upd_ctr;
  logic                       pht_we;
  logic                       ready;
  logic                       unused_bits;

  assign ready = (state_q == StReady);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  assign fetch_idx  = fetchPc[PHT_INDEX_WIDTH+1:2] ^ PHT_INDEX_WIDTH'(ghr_q);
  assign update_idx = updatePc[PHT_INDEX_WIDTH+1:2] ^ PHT_INDEX_WIDTH'(updateHistory);
`else
  assign fetch_idx  = fetchPc[PHT_INDEX_WIDTH+1:2];
  assign update_idx = updatePc[PHT_INDEX_WIDTH+1:2];
`endif

  // Only the index bits of the PCs matter; the rest are intentionally ignored.
  assign unused_bits = ^{fetchPc, updatePc, updateHistory};

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign isBranchTakenPredicted = ready & pht_q[fetch_idx][1];
  assign globalBranchHistory    = ghr_q;
  assign predictorReady         = ready;
  assign upd_ctr                = pht_q[update_idx];

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    ghr_d     = ghr_q;
    pht_we    = 1'b0;
    pht_waddr = sweep_q;
    pht_wdata = 2'b01;
    if (state_q == StInit) begin
      pht_we  = 1'b1;
      sweep_d = sweep_q + 1'b1;
      if (&sweep_q) begin
        state_d = StReady;
      end
    end else begin
      if (updateValid) begin
        pht_we    = 1'b1;
        pht_waddr = update_idx;
        if (updateTaken) begin
          pht_wdata = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
        end else begin
          pht_wdata = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
        end
      end
      // A mispredict repair wins and discards any same-cycle speculative shift.
      if (updateValid && updateMispredicted) begin
        ghr_d = {updateHistory[HISTORY_WIDTH-2:0], updateTaken};
      end else if (fetchValid && isBranch && !stall) begin
        ghr_d = {ghr_q[HISTORY_WIDTH-2:0], isBranchTakenPredicted};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && pht_we) begin
      pht_q[pht_waddr] <= pht_wdata;
    end
  end

endmodule

// File: tb/tb_branch_direction_predictor.sv
// Directed and random checks of branch_direction_predictor against a counter-array reference model.
module tb_branch_direction_predictor;
  logic        clk = 1'b0;
  logic        rst, fetchValid, isBranch, stall;
  logic        updateValid, updateTaken, updateMispredicted;
  logic [31:0] fetchPc, updatePc;
  logic [3:0]  updateHistory, globalBranchHistory;
  logic        isBranchTakenPredicted, predictorReady;

  int total = 0;
  int bad   = 0;

  int m_pht [64];
  int m_ghr;
  bit m_ready;
  int m_init_left;

  always #5 clk = ~clk;

  branch_direction_predictor dut (
    .clk                    (clk),
    .rst                    (rst),
    .fetchValid             (fetchValid),
    .fetchPc                (fetchPc),
    .isBranch               (isBranch),
    .stall                  (stall),
    .isBranchTakenPredicted (isBranchTakenPredicted),
    .globalBranchHistory    (globalBranchHistory),
    .predictorReady         (predictorReady),
    .updateValid            (updateValid),
    .updatePc               (updatePc),
    .updateHistory          (updateHistory),
    .updateTaken            (updateTaken),
    .updateMispredicted     (updateMispredicted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc, input int h);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return (int'(pc >> 2) ^ h) & 63;
`else
    return int'(pc >> 2) & 63;
`endif
  endfunction

  function automatic int m_pred();
    if (!m_ready) return 0;
    return (m_pht[m_idx(fetchPc, m_ghr)] >= 2) ? 1 : 0;
  endfunction

  task automatic idle();
    fetchValid = 0; isBranch = 0; stall = 0; fetchPc = 0;
    updateValid = 0; updatePc = 0; updateHistory = 0; updateTaken = 0; updateMispredicted = 0;
  endtask

  // One clock: check outputs against the model, then advance the model with the applied inputs.
  task automatic cycle();
    int p;
    int ui;
    #1;
    chk("ready", predictorReady, m_ready);
    chk("ghr", globalBranchHistory, m_ghr);
    p = m_pred();
    chk("pred", isBranchTakenPredicted, p);
    @(posedge clk);
    if (rst) begin
      m_ready = 0; m_init_left = 64; m_ghr = 0;
    end else if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) begin
        m_ready = 1;
        foreach (m_pht[i]) m_pht[i] = 1;
      end
    end else begin
      if (updateValid) begin
        ui = m_idx(updatePc, int'(updateHistory));
        if (updateTaken) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
        else             m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
      end
      if (updateValid && updateMispredicted) m_ghr = ((int'(updateHistory) << 1) | updateTaken) & 15;
      else if (fetchValid && isBranch && !stall) m_ghr = ((m_ghr << 1) | p) & 15;
    end
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!predictorReady && n < 200) begin
      cycle();
      n++;
    end
  endtask

  task automatic do_reset();
    int n;
    idle();
    rst = 1;
    cycle();
    rst = 0;
    wait_ready(n);
    chk("init_len", n, 64);
  endtask

  task automatic train(input logic [31:0] pc, input logic [3:0] h, input logic t, input int k);
    updateValid = 1; updatePc = pc; updateHistory = h; updateTaken = t; updateMispredicted = 0;
    for (int i = 0; i < k; i++) cycle();
    updateValid = 0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
    fetchPc = pc;
    #1;
    chk(tag, isBranchTakenPredicted, exp);
    chk({tag, "_model"}, isBranchTakenPredicted, m_pred());
  endtask

  initial begin
    int n;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    m_ready = 0; m_init_left = 64; m_ghr = 0;
    foreach (m_pht[i]) m_pht[i] = 1;
    cycle();
    chk("rst_ready", predictorReady, 0);
    chk("rst_ghr", globalBranchHistory, 0);
    chk("rst_pred", isBranchTakenPredicted, 0);
    rst = 0;
    wait_ready(n);
    chk("init_len", n, 64);

    fetchValid = 1;
    for (int i = 0; i < 64; i++) begin
      fetchPc = 32'(i) << 2;
      #1;
      chk("init_not_taken", isBranchTakenPredicted, 0);
    end
    idle();

    train(32'h100, 4'h0, 1, 2);
    lookup("train_tt", 32'h100, 1);
    train(32'h100, 4'h0, 0, 1);
    lookup("train_ttn", 32'h100, 1);
    train(32'h100, 4'h0, 0, 1);
    lookup("train_ttnn", 32'h100, 0);

    train(32'h100, 4'h0, 1, 5);
    train(32'h100, 4'h0, 0, 1);
    lookup("sat_hi", 32'h100, 1);
    train(32'h100, 4'h0, 0, 5);
    train(32'h100, 4'h0, 1, 1);
    lookup("sat_lo", 32'h100, 0);

    do_reset();
    train(32'h300, 4'h0, 1, 2);
    train(32'h300, 4'h1, 1, 2);
    train(32'h300, 4'h3, 1, 2);
    fetchValid = 1; isBranch = 1; fetchPc = 32'h300;
    for (int i = 0; i < 3; i++) cycle();
    chk("ghr_0111", globalBranchHistory, 4'b0111);
    stall = 1;
    cycle();
    chk("ghr_stall", globalBranchHistory, 4'b0111);
    stall = 0;
    updateValid = 1; updateMispredicted = 1; updateHistory = 4'b1010; updateTaken = 0;
    updatePc = 32'h500;
    cycle();
    chk("ghr_repair", globalBranchHistory, 4'b0100);
    idle();

    do_reset();
    train(32'h100, 4'h0, 1, 2);
    updateValid = 1; updateMispredicted = 1; updatePc = 32'h3f0; updateHistory = 4'h0;
    updateTaken = 1;
    cycle();
    idle();
    chk("ghr_0001", globalBranchHistory, 4'b0001);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    lookup("gshare_alias", 32'h100, 0);
`else
    lookup("bimodal_share", 32'h100, 1);
`endif

    idle();
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < 30; i++) cycle();
    rst = 1;
    cycle();
    rst = 0;
    n = 0;
    updateValid = 1; updatePc = 32'h100; updateTaken = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      n++;
    end
    chk("init_update_ready", predictorReady, 0);
    updateValid = 0;
    while (!predictorReady && n < 200) begin
      cycle();
      n++;
    end
    chk("restart_len", n, 64);
    lookup("init_update_ignored", 32'h100, 0);

    for (int i = 0; i < 400; i++) begin
      fetchValid         = 1'($urandom_range(0, 1));
      isBranch           = ($urandom_range(0, 3) != 0);
      stall              = ($urandom_range(0, 3) == 0);
      fetchPc            = 32'($urandom_range(0, 255)) << 2;
      updateValid        = 1'($urandom_range(0, 1));
      updatePc           = 32'($urandom_range(0, 255)) << 2;
      updateHistory      = 4'($urandom_range(0, 15));
      updateTaken        = 1'($urandom_range(0, 1));
      updateMispredicted = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
